// File: rtl/stack_pkg.sv
// Shared encodings for the data-stack cache controller: operation codes and sequencer states.
package stack_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    typedef enum logic {
        ST_READY  = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

endpackage

// File: rtl/stack_cache_ctrl.sv
// Data-stack sequencer: T and N live in registers, deeper entries spill to and refill from a
// single-port stack RAM. The controller's registered address/strobe act as the RAM's input stage.
module stack_cache_ctrl
    import stack_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [1:0]          i_op,
    input  logic [WIDTH-1:0]    i_data,
    output logic [WIDTH-1:0]    o_tos,
    output logic [WIDTH-1:0]    o_nos,
    output logic [ADDR_W+1:0]   o_depth,
    output logic                o_empty,
    output logic                o_full,
    output logic                o_overflow,
    output logic                o_underflow,
    input  logic                i_clear_err,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_we,
    output logic                o_mem_re,
    output logic [WIDTH-1:0]    o_mem_wdata,
    input  logic [WIDTH-1:0]    i_mem_rdata
);

    localparam int DW = ADDR_W + 2;
    localparam int SW = ADDR_W + 1;
    localparam logic [DW-1:0]     CAP     = DW'(2 ** ADDR_W + 2);
    localparam logic [DW-1:0]     D_ONE   = DW'(1);
    localparam logic [DW-1:0]     D_TWO   = DW'(2);
    localparam logic [SW-1:0]     SP_ONE  = SW'(1);
    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    tos_q, tos_d;
    logic [WIDTH-1:0]    nos_q, nos_d;
    logic [SW-1:0]       sp_q, sp_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;
    logic                do_push;

    always_comb begin
        state_d     = state_q;
        tos_d       = tos_q;
        nos_d       = nos_q;
        sp_d        = sp_q;
        depth_d     = depth_q;
        // A fresh error in the same cycle overrides a clear request.
        ovf_d       = ovf_q & ~i_clear_err;
        unf_d       = unf_q & ~i_clear_err;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        do_push     = 1'b0;

        case (state_q)
            ST_READY: begin
                if (i_valid) begin
                    case (i_op)
                        OP_PUSH: do_push = 1'b1;
                        OP_POP: begin
                            if (depth_q == '0) begin
                                unf_d = 1'b1;
                            end else if (depth_q > D_TWO) begin
                                tos_d      = nos_q;
                                mem_re_d   = 1'b1;
                                mem_addr_d = sp_q[ADDR_W-1:0] - A_ONE;
                                sp_d       = sp_q - SP_ONE;
                                depth_d    = depth_q - D_ONE;
                                state_d    = ST_REFILL;
                            end else begin
                                tos_d   = nos_q;
                                nos_d   = '0;
                                depth_d = depth_q - D_ONE;
                            end
                        end
                        OP_REPL: begin
                            if (depth_q == '0) do_push = 1'b1;
                            else               tos_d   = i_data;
                        end
                        default: ;
                    endcase

                    if (do_push) begin
                        if (depth_q == CAP) begin
                            ovf_d = 1'b1;
                        end else begin
                            // Once both cache slots are live, N is spilled to make room.
                            if (depth_q >= D_TWO) begin
                                mem_we_d    = 1'b1;
                                mem_addr_d  = sp_q[ADDR_W-1:0];
                                mem_wdata_d = nos_q;
                                sp_d        = sp_q + SP_ONE;
                            end
                            nos_d   = tos_q;
                            tos_d   = i_data;
                            depth_d = depth_q + D_ONE;
                        end
                    end
                end
            end
            ST_REFILL: begin
                nos_d   = i_mem_rdata;
                state_d = ST_READY;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_READY;
            tos_q       <= '0;
            nos_q       <= '0;
            sp_q        <= '0;
            depth_q     <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tos_q       <= tos_d;
            nos_q       <= nos_d;
            sp_q        <= sp_d;
            depth_q     <= depth_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
        end
    end

    assign o_ready     = (state_q == ST_READY);
    assign o_tos       = tos_q;
    assign o_nos       = nos_q;
    assign o_depth     = depth_q;
    assign o_empty     = (depth_q == '0);
    assign o_full      = (depth_q == CAP);
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_re    = mem_re_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule
